// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_add_ctrl_if                                              |
// | Brief    : start/operand request and busy/done/result response bundle      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface serial_add_ctrl_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_add_ctrl                                                 |
// | Brief    : bit-serial N-bit adder sequencer around a single full-adder     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module serial_add_ctrl #(
  parameter int N = 8
) (
  input  wire                clk,
  input  wire                rst,
  serial_add_ctrl_if.slave   bus
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_sum;
  logic          r_carry;
  logic          r_cout;
  logic [CW-1:0] r_count;

  logic          w_load;
  logic          w_step;
  logic          w_last;
  logic          w_busy;
  logic          w_done;
  logic          w_s;
  logic          w_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = bus.start ? S_RUN : S_IDLE;
      S_RUN:   w_next = (r_count == C_LAST) ? S_DONE : S_RUN;
      S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output / control decode from the registered state
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      S_IDLE: w_load = bus.start;
      S_RUN: begin
        w_busy = 1'b1;
        w_step = 1'b1;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_load = bus.start;
      end
      default: ;
    endcase
  end

  assign w_last = (r_count == C_LAST);
  assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c    = (r_a[0] & r_b[0]) | (r_b[0] & r_carry) | (r_a[0] & r_carry);

  // Datapath: the newest sum bit enters at the MSB so that after N shifts
  // the result is LSB-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_count <= '0;
    end else if (w_load) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_sum   <= '0;
      r_carry <= bus.cin;
      r_count <= '0;
    end else if (w_step) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= (r_sum >> 1) | (N'(w_s) << (N - 1));
      r_carry <= w_c;
      r_count <= r_count + CW'(1);
      if (w_last) begin
        r_cout <= w_c;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_serial_add_ctrl                                              |
// | Brief    : directed table, corner sequences and random sweep over N       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // ---------------- directed instance, N=8 ----------------
  serial_add_ctrl_if #(.N(8)) bus8 ();
  serial_add_ctrl #(.N(8)) dut (.clk(clk), .rst(rst), .bus(bus8.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] esum;
    logic       ecout;
  } vec_t;

  vec_t tbl [7];

  // Counts negedges after the start-driving negedge until done appears;
  // optionally injects a start pulse at cycle inj.
  task automatic await_done(input int maxc, input int inj, output int lat, output int busyc, output int ovl);
    lat = -1; busyc = 0; ovl = 0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (bus8.busy && bus8.done) ovl++;
      if (bus8.done) begin
        lat = c;
        break;
      end
      if (bus8.busy) busyc++;
      if (c == inj) begin
        bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0;
      end else begin
        bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
      end
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic [7:0] esum, input logic ecout, input string nm,
                      input bit here, input int inj);
    int lat, bc, ov;
    if (!here) @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
    await_done(20, inj, lat, bc, ov);
    chk({nm, " done_latency"}, 64'(lat), 64'd9);
    chk({nm, " busy_cycles"}, 64'(bc + ov), 64'd8);
    chk({nm, " sum"}, 64'(bus8.sum), 64'(esum));
    chk({nm, " cout"}, 64'(bus8.cout), 64'(ecout));
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      bus8.start = 1'b0;
      if (bus8.done) cnt++;
    end
  endtask

  // ---------------- random sweep instances ----------------
  localparam int NS [4] = '{1, 5, 8, 16};
  bit sweep_go = 1'b0;
  bit [3:0] sweep_fin = '0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    localparam int NN = NS[gi];
    serial_add_ctrl_if #(.N(NN)) bus ();
    serial_add_ctrl #(.N(NN)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    logic [NN-1:0] ra, rb;
    logic          rc;
    logic [32:0]   e;
    int            lat;
    int            bad_busy;
    bit            pend;

    initial begin
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      wait (sweep_go);
      pend = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        if (!pend) @(negedge clk);
        ra = NN'($urandom); rb = NN'($urandom); rc = 1'($urandom);
        bus.start = 1'b1; bus.a = ra; bus.b = rb; bus.cin = rc;
        lat = -1; bad_busy = 0;
        for (int c = 1; c <= NN + 1; c++) begin
          @(negedge clk);
          bus.start = 1'b0; bus.a = NN'($urandom); bus.b = NN'($urandom); bus.cin = 1'($urandom);
          if (bus.done && lat < 0) lat = c;
          if (bus.busy != (c <= NN)) bad_busy++;
        end
        e = 33'(ra) + 33'(rb) + 33'(rc);
        chk($sformatf("sweep N=%0d latency", NN), 64'(lat), 64'(NN + 1));
        chk($sformatf("sweep N=%0d busy_window", NN), 64'(bad_busy), 64'd0);
        chk($sformatf("sweep N=%0d result a=%0h b=%0h cin=%0d", NN, ra, rb, rc),
            64'({bus.cout, bus.sum}), 64'(e[NN:0]));
        pend = 1'($urandom_range(0, 1));
      end
      sweep_fin[gi] = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tbl[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset outputs", 64'({bus8.busy, bus8.done, bus8.sum, bus8.cout}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].esum, tbl[i].ecout,
           $sformatf("vec%0d", i), 1'b0, 0);
      count_done(1, cnt);
      chk($sformatf("vec%0d hold_sum", i), 64'(bus8.sum), 64'(tbl[i].esum));
    end

    // start during RUN must be ignored
    run8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "ignored_start", 1'b0, 3);
    count_done(12, cnt);
    chk("ignored_start no_second_done", 64'(cnt), 64'd0);

    // back-to-back start in the DONE cycle
    run8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "b2b_first", 1'b0, 0);
    run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "b2b_second", 1'b1, 0);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bus8.start = 1'b0;
    end
    chk("midrun busy_before_reset", 64'(bus8.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrun reset busy", 64'(bus8.busy), 64'd0);
    chk("midrun reset done", 64'(bus8.done), 64'd0);
    chk("midrun reset sum", 64'(bus8.sum), 64'd0);
    chk("midrun reset cout", 64'(bus8.cout), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    count_done(12, cnt);
    chk("midrun no_done_after_reset", 64'(cnt), 64'd0);
    run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "post_reset", 1'b0, 0);

    sweep_go = 1'b1;
    for (int c = 0; c < 60000 && !(&sweep_fin); c++) @(posedge clk);
    chk("sweep completion", 64'(&sweep_fin), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencer that computes an N-bit sum one bit per clock using a single full-adder cell (a + b + carry-in, sum = XOR of the three inputs, carry-out = majority) and a registered carry. It sits between a requester that supplies operands with a start pulse and the full-adder datapath. It owns the operand and sum shift registers, the carry flop, the bit counter and the start/busy/done handshake. It trades N cycles of latency for one adder cell instead of N.

## Interface
- N, default 8, operand width in bits; legal range 1..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- a  input  N  operand A; sampled on the edge that accepts start.
- b  input  N  operand B; sampled on the edge that accepts start.
- cin  input  1  initial carry; sampled on the edge that accepts start.
- busy  output  1  high while in RUN.
- done  output  1  high for exactly one cycle (DONE state) when the result is complete.
- sum  output  N  result register.
- cout  output  1  final carry.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: one bit processed per edge.
  - DONE: result presented for one cycle.
- IDLE, start=1: load A shift register ← a, B shift register ← b, carry ← cin, count ← 0, sum ← 0; go to RUN.
- IDLE, start=0: stay in IDLE; all registers hold.
- RUN, every edge:
  - Compute s = A[0]^B[0]^carry and c = A[0]&B[0] | B[0]&carry | A[0]&carry.
  - A and B shift right by 1.
  - sum shifts right by 1 with s entering at sum[N-1].
  - carry ← c; count ← count+1.
- RUN exit: on the edge where count == N-1 (last bit), state → DONE and cout ← c. sum then holds a+b+cin mod 2^N, LSB-aligned.
- DONE, start=1: load exactly as from IDLE and go directly to RUN (back-to-back operation).
- DONE, start=0: go to IDLE.
- start while in RUN is ignored; it is neither queued nor allowed to disturb the operation in progress.
- Operand inputs are don't-care except on the accepting edge.
- sum and cout hold their values after DONE until the next accepted start. Across IDLE they keep the last result.
- During RUN, sum holds partial, shifting data and is not valid. cout holds its previous value until the last RUN edge.
- Counter width is clog2(N)+1. There is no wrap: count resets on every load.
- N=1: a single RUN edge, then DONE.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - carry=0, count=0, A and B shift registers = 0.
- Reset asserted mid-RUN aborts the operation. No done is produced for it.
- After reset is released, the first rising edge with start=1 is accepted.
- Latency: start accepted at edge t.
  - busy=1 from after edge t until after edge t+N.
  - done=1 in the cycle between edges t+N and t+N+1.
  - sum and cout are valid in that same cycle.
- busy and done are never high together. Both are registered and decoded from state only.
- Throughput with back-to-back starts: one result every N+1 cycles.

## Test plan
- Reset, then N=8, a=0x5A, b=0x3C, cin=0, start pulse → busy high for 8 cycles, done high exactly 8 cycles after the accepting edge, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start at a=0x0F, b=0x01; pulse start again with a=0xAA, b=0x55 during RUN (cycle 3) → ignored, done once, sum=0x10, cout=0, no second done.
- Hold start=1 with new operands (a=0x80, b=0x80, cin=0) in the DONE cycle → RUN entered at the next edge without an IDLE cycle. First done shows the prior result; second done, 9 cycles later, shows sum=0x00, cout=1.
- Assert rst at RUN cycle 4 of a=0x12, b=0x34 → busy, done, sum and cout go to 0 immediately. No done afterwards. A new start with a=0x01, b=0x01 yields sum=0x02.
- Random sweep over N=1, 5, 8, 16: 1000 random a, b, cin values → {cout, sum} == a+b+cin. done timing is exactly N cycles after the accepting edge.
